// File: rtl/conv_tile_scheduler_if.sv
// Control/result handshake bundle between host, convolution PE and result buffer.
// The scheduler takes the slave side; host/PE/buffer logic takes the master side.
interface conv_tile_scheduler_if #(
   parameter int TILE_W = 2
);
   logic              start;
   logic [TILE_W:0]   num_tiles;
   logic              abort;
   logic              kernel_load_en;
   logic [TILE_W-1:0] tile_sel;
   logic              pe_start;
   logic              res_valid;
   logic              res_ready;
   logic [TILE_W-1:0] res_tile;
   logic              busy;
   logic              done;

   modport slave (
      input  start, num_tiles, abort, res_ready,
      output kernel_load_en, tile_sel, pe_start, res_valid, res_tile, busy, done
   );

   modport master (
      output start, num_tiles, abort, res_ready,
      input  kernel_load_en, tile_sel, pe_start, res_valid, res_tile, busy, done
   );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Time-shares one 3x3 convolution PE across the output tiles of a feature map:
// kernel load, per-tile issue, latency wait, result handshake, job-done pulse.
module conv_tile_scheduler #(
   parameter int N_TILES = 4,
   parameter int TILE_W  = 2,
   parameter int PE_LAT  = 0,
   parameter int LAT_W   = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   conv_tile_scheduler_if.slave sched
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [TILE_W:0]  MAX_N    = (TILE_W+1)'(N_TILES);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PE_LAT);

   state_t            r_state;
   state_t            w_state_next;
   logic [TILE_W-1:0] r_tile;
   logic [TILE_W-1:0] r_tile_sel;
   logic [TILE_W-1:0] r_last;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic [TILE_W:0]   w_n_clamped;
   logic [TILE_W:0]   w_n_minus1;
   logic              w_abort;

   assign w_n_clamped = (sched.num_tiles > MAX_N) ? MAX_N : sched.num_tiles;
   assign w_n_minus1  = w_n_clamped - (TILE_W+1)'(1);
   assign w_abort     = sched.abort && (r_state != ST_IDLE);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; abort outranks every other transition
   always_comb begin
      w_state_next = r_state;
      if (w_abort) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (sched.start) begin
                  w_state_next = (w_n_clamped == '0) ? ST_DONE : ST_LOAD;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
            ST_LOAD:  w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = (PE_LAT == 0) ? ST_WRITE : ST_WAIT;
            ST_WAIT: begin
               if (r_lat_cnt <= LAT_W'(1)) begin
                  w_state_next = ST_WRITE;
               end else begin
                  w_state_next = ST_WAIT;
               end
            end
            ST_WRITE: begin
               if (sched.res_ready) begin
                  w_state_next = (r_tile == r_last) ? ST_DONE : ST_ISSUE;
               end else begin
                  w_state_next = ST_WRITE;
               end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   // Tile index, last-tile bound, mux select and latency counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tile     <= '0;
         r_tile_sel <= '0;
         r_last     <= '0;
         r_lat_cnt  <= '0;
      end else if (w_abort) begin
         r_tile    <= '0;
         r_lat_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (sched.start && (w_n_clamped != '0)) begin
                  r_tile <= '0;
                  r_last <= w_n_minus1[TILE_W-1:0];
               end
            end
            // tile_sel is loaded on the way into ISSUE so it is valid with pe_start
            ST_LOAD:  r_tile_sel <= r_tile;
            ST_ISSUE: r_lat_cnt  <= LAT_INIT;
            ST_WAIT:  r_lat_cnt  <= r_lat_cnt - LAT_W'(1);
            ST_WRITE: begin
               if (sched.res_ready && (r_tile != r_last)) begin
                  r_tile     <= r_tile + TILE_W'(1);
                  r_tile_sel <= r_tile + TILE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Moore output decode from the state register
   always_comb begin
      sched.kernel_load_en = (r_state == ST_LOAD);
      sched.pe_start       = (r_state == ST_ISSUE);
      sched.res_valid      = (r_state == ST_WRITE);
      sched.busy           = (r_state != ST_IDLE);
      sched.done           = (r_state == ST_DONE);
      sched.tile_sel       = r_tile_sel;
      sched.res_tile       = r_tile;
   end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Randomized bench for conv_tile_scheduler: a PE_LAT=0 and a PE_LAT=3 instance share
// stimulus and are each compared cycle by cycle against a job-timeline model.
module tb_conv_tile_scheduler;
   localparam int MAXC = 60;
   localparam int AW   = 128;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic       res_ready;
   logic [2:0] num_tiles;

   int n_checks = 0;
   int n_fail   = 0;

   int rdy   [0:AW-1];
   int e_kl  [0:1][0:AW-1];
   int e_ps  [0:1][0:AW-1];
   int e_ts  [0:1][0:AW-1];
   int e_rv  [0:1][0:AW-1];
   int e_rt  [0:1][0:AW-1];
   int e_bsy [0:1][0:AW-1];
   int e_dn  [0:1][0:AW-1];

   always #5 clk = ~clk;

   conv_tile_scheduler_if #(.TILE_W(2)) if0 ();
   conv_tile_scheduler_if #(.TILE_W(2)) if3 ();

   assign if0.start = start;  assign if0.num_tiles = num_tiles;
   assign if0.abort = abort;  assign if0.res_ready = res_ready;
   assign if3.start = start;  assign if3.num_tiles = num_tiles;
   assign if3.abort = abort;  assign if3.res_ready = res_ready;

   conv_tile_scheduler #(.N_TILES(4), .TILE_W(2), .PE_LAT(0), .LAT_W(4)) dut0 (
      .clk(clk), .reset_n(reset_n), .sched(if0));
   conv_tile_scheduler #(.N_TILES(4), .TILE_W(2), .PE_LAT(3), .LAT_W(4)) dut3 (
      .clk(clk), .reset_n(reset_n), .sched(if3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected per-cycle outputs of one job started at edge 0 (cycle 1 follows that edge)
   task automatic build(input int d, input int nreq, input int ac);
      int n, c, lat, last;
      lat = (d == 0) ? 0 : 3;
      for (int k = 0; k < AW; k++) begin
         e_kl[d][k] = 0; e_ps[d][k] = 0; e_ts[d][k] = 0; e_rv[d][k] = 0;
         e_rt[d][k] = 0; e_bsy[d][k] = 0; e_dn[d][k] = 0;
      end
      n = (nreq > 4) ? 4 : nreq;
      if (n == 0) begin
         last = 1;
      end else begin
         e_kl[d][1] = 1;
         c = 2;
         for (int t = 0; t < n; t++) begin
            e_ps[d][c] = 1; e_ts[d][c] = t;
            c = c + 1 + lat;
            while (c < AW - 2 && rdy[c] == 0) begin
               e_rv[d][c] = 1; e_rt[d][c] = t; c++;
            end
            e_rv[d][c] = 1; e_rt[d][c] = t; c++;
         end
         last = c;
      end
      e_dn[d][last] = 1;
      for (int k = 1; k <= last; k++) e_bsy[d][k] = 1;
      if (ac >= 1 && ac <= last) begin
         for (int k = ac + 1; k < AW; k++) begin
            e_kl[d][k] = 0; e_ps[d][k] = 0; e_rv[d][k] = 0;
            e_bsy[d][k] = 0; e_dn[d][k] = 0;
         end
      end
   endtask

   task automatic cmp(input int d, input int c, input logic kl, input logic ps, input logic [1:0] ts,
                      input logic rv, input logic [1:0] rt, input logic bsy, input logic dn);
      string p;
      p = $sformatf("lat%0d c%0d", (d == 0) ? 0 : 3, c);
      check({p, " kernel_load_en"}, kl, e_kl[d][c]);
      check({p, " pe_start"}, ps, e_ps[d][c]);
      check({p, " res_valid"}, rv, e_rv[d][c]);
      check({p, " busy"}, bsy, e_bsy[d][c]);
      check({p, " done"}, dn, e_dn[d][c]);
      if (e_ps[d][c] == 1) check({p, " tile_sel"}, ts, e_ts[d][c]);
      if (e_rv[d][c] == 1) check({p, " res_tile"}, rt, e_rt[d][c]);
   endtask

   // Entered just after a posedge with both instances idle
   task automatic run_job(input int nreq, input logic ab0, input int ac, input int xs_in);
      int xs;
      build(0, nreq, ac);
      build(1, nreq, ac);
      xs = xs_in;
      if (xs > 0 && (e_bsy[0][xs] == 0 || e_bsy[1][xs] == 0 || (ac > 0 && xs > ac))) xs = 0;
      start = 1'b1; num_tiles = 3'(nreq); abort = ab0; res_ready = rdy[0] != 0;
      @(posedge clk); #1;
      for (int c = 1; c <= MAXC; c++) begin
         start     = (c == xs);
         abort     = (c == ac);
         num_tiles = 3'($urandom_range(0, 7));
         res_ready = rdy[c] != 0;
         @(negedge clk);
         cmp(0, c, if0.kernel_load_en, if0.pe_start, if0.tile_sel, if0.res_valid,
             if0.res_tile, if0.busy, if0.done);
         cmp(1, c, if3.kernel_load_en, if3.pe_start, if3.tile_sel, if3.res_valid,
             if3.res_tile, if3.busy, if3.done);
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0; res_ready = 1'b0; num_tiles = 3'd0;
   endtask

   task automatic rdy_all_high();
      for (int k = 0; k < AW; k++) rdy[k] = 1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " lat0 outputs"}, {if0.kernel_load_en, if0.pe_start, if0.tile_sel, if0.res_valid,
                                     if0.res_tile, if0.busy, if0.done}, 32'd0);
      check({tag, " lat3 outputs"}, {if3.kernel_load_en, if3.pe_start, if3.tile_sel, if3.res_valid,
                                     if3.res_tile, if3.busy, if3.done}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0; num_tiles = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      rdy_all_high();
      run_job(4, 1'b0, 0, 0);                      // default job
      rdy_all_high(); rdy[5] = 0; rdy[6] = 0; rdy[7] = 0;
      run_job(4, 1'b0, 0, 0);                      // backpressure on tile 1
      rdy_all_high();
      run_job(2, 1'b0, 0, 0);                      // two tiles
      run_job(0, 1'b0, 0, 0);                      // empty job
      run_job(7, 1'b0, 0, 0);                      // clamped to 4
      run_job(4, 1'b0, 14, 0);                     // abort in tile-2 WAIT of lat3
      run_job(4, 1'b1, 0, 3);                      // start+abort in IDLE, start while busy
      run_job(3, 1'b0, 0, 0);                      // fresh job after the above

      // Asynchronous reset in the middle of a WRITE
      rdy_all_high();
      start = 1'b1; num_tiles = 3'd4;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre-reset lat0 res_valid", if0.res_valid, 32'd1);
      check("pre-reset lat3 busy", if3.busy, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("async reset");
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      for (int j = 0; j < 40; j++) begin
         for (int k = 0; k < AW; k++) rdy[k] = (k >= 30) ? 1 : (($urandom % 4) != 0);
         run_job($urandom_range(0, 7), 1'($urandom % 2),
                 (($urandom % 3) == 0) ? $urandom_range(1, 25) : 0,
                 (($urandom % 2) == 0) ? $urandom_range(1, 20) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
